rv_plic_scan_arb: RTL and testbench

- Sequential per-target arbiter for the PLIC.
- Scans pending and enabled sources a fixed number per cycle and keeps the best (priority, ID) candidate in a register.
- At the end of each sweep, commits irq_o/irq_id_o.
- Owns the claim handshake for one target: returns the claimed ID and pulses the one-hot claim vector back to the gateways.
- Replaces the flat single-cycle 55-way max tree to relieve timing.

---
 rtl/rv_plic_scan_pkg.sv | 34 +++
 rtl/rv_plic_scan_chunk.sv | 26 ++
 rtl/rv_plic_scan_arb.sv | 109 ++++++++++
 tb/tb_rv_plic_scan_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_plic_scan_pkg.sv
// Shared types and constants for the sequential PLIC target arbiter.
// Sizing lives here so the top and the chunk reducer agree on the layout.
package rv_plic_scan_pkg;

  localparam int NumSrc      = 55;  // source index == interrupt ID
  localparam int PrioW       = 2;
  localparam int SrcW        = 6;   // 2**SrcW >= NumSrc
  localparam int SrcPerCycle = 8;   // 1..NumSrc

  // SCAN cycles per sweep; one COMMIT cycle follows each sweep.
  localparam int NSweep = (NumSrc + SrcPerCycle - 1) / SrcPerCycle;
  // Source vectors are zero-padded to whole chunks so a partial last chunk
  // never selects beyond the real inputs.
  localparam int NPad   = NSweep * SrcPerCycle;
  localparam int ChunkW = (NSweep > 1) ? $clog2(NSweep) : 1;

  typedef enum logic {
    SCAN   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [PrioW-1:0] prio;
    logic [SrcW-1:0]  id;
  } cand_t;

  // True when a should replace b. Equal priority keeps b; since sources are
  // visited in ascending ID order, the lowest ID wins a tie.
  function automatic logic better(cand_t a, cand_t b);
    return a.vld && (!b.vld || (a.prio > b.prio));
  endfunction

endpackage

// File: rtl/rv_plic_scan_chunk.sv
// Combinational reduction of one SrcPerCycle-wide chunk to its best candidate.
module rv_plic_scan_chunk
  import rv_plic_scan_pkg::*;
(
  input  logic [SrcPerCycle-1:0]       act_i,        // pending & enabled
  input  logic [SrcPerCycle*PrioW-1:0] prio_i,
  input  logic [PrioW-1:0]             threshold_i,
  input  logic [SrcW-1:0]              base_id_i,    // ID of lane 0
  output cand_t                        best_o
);

  // Ascending linear scan of the lanes, keeping the strict maximum.
  always_comb begin
    cand_t cand;
    // NOTE: every output and local gets a value before any condition, so no latch is inferred.
    best_o = '0;
    cand   = '0;
    for (int j = 0; j < SrcPerCycle; j++) begin
      cand.prio = prio_i[j*PrioW +: PrioW];
      cand.vld  = act_i[j] && (cand.prio > threshold_i);
      cand.id   = base_id_i + SrcW'(j);
      if (better(cand, best_o)) best_o = cand;
    end
  end

endmodule

// File: rtl/rv_plic_scan_arb.sv
// Sequential per-target PLIC arbiter: sweeps the sources one chunk per cycle,
// commits the winner to irq_o/irq_id_o after each sweep, and answers claims.
// Optional: define RV_PLIC_SCAN_ARB_SPURCNT_EN to count claims that find no
// interrupt (spur_cnt_o, saturating); otherwise spur_cnt_o is tied to 0.
module rv_plic_scan_arb
  import rv_plic_scan_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumSrc-1:0]       ip_i,
  input  logic [NumSrc-1:0]       ie_i,
  input  logic [NumSrc*PrioW-1:0] prio_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_req_i,
  output logic                    claim_ack_o,
  output logic [SrcW-1:0]         claim_id_o,
  output logic [NumSrc-1:0]       claim_o,
  output logic                    irq_o,
  output logic [SrcW-1:0]         irq_id_o,
  output logic [15:0]             spur_cnt_o
);

  state_e              state_q;
  logic [ChunkW-1:0]   chunk_q;
  cand_t               best_q;
  cand_t               chunk_best;
  logic [NPad-1:0]       act_pad;
  logic [NPad*PrioW-1:0] prio_pad;
  int                  base;

  // Zero-pad the source vectors to whole chunks and locate the current chunk.
  always_comb begin
    act_pad                      = '0;
    act_pad[NumSrc-1:0]          = ip_i & ie_i;
    prio_pad                     = '0;
    prio_pad[NumSrc*PrioW-1:0]   = prio_i;
    base                         = int'(chunk_q) * SrcPerCycle;
  end

  rv_plic_scan_chunk u_chunk (
    .act_i       (act_pad[base +: SrcPerCycle]),
    .prio_i      (prio_pad[base*PrioW +: SrcPerCycle*PrioW]),
    .threshold_i (threshold_i),
    .base_id_i   (SrcW'(base)),
    .best_o      (chunk_best)
  );

  // Sweep FSM, best register, committed outputs and the claim handshake.
  // A claim outranks COMMIT: it consumes the pre-commit value and restarts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCAN;
      chunk_q     <= '0;
      best_q      <= '0;
      irq_o       <= 1'b0;
      irq_id_o    <= '0;
      claim_ack_o <= 1'b0;
      claim_id_o  <= '0;
      claim_o     <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      claim_ack_o <= 1'b0;
      claim_o     <= '0;
      if (claim_req_i) begin
        claim_ack_o <= 1'b1;
        claim_id_o  <= irq_o ? irq_id_o : '0;
        claim_o     <= irq_o ? (NumSrc'(1) << irq_id_o) : '0;
        irq_o       <= 1'b0;
        irq_id_o    <= '0;
        best_q      <= '0;
        chunk_q     <= '0;
        state_q     <= SCAN;
      end else begin
        case (state_q)
          SCAN: begin
            if (better(chunk_best, best_q)) best_q <= chunk_best;
            if (chunk_q == ChunkW'(NSweep - 1)) begin
              chunk_q <= '0;
              state_q <= COMMIT;
            end else begin
              chunk_q <= chunk_q + 1'b1;
            end
          end
          COMMIT: begin
            irq_o    <= best_q.vld;
            irq_id_o <= best_q.vld ? best_q.id : '0;
            best_q   <= '0;
            state_q  <= SCAN;
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

`ifdef RV_PLIC_SCAN_ARB_SPURCNT_EN
  // Saturating count of claims answered with ID 0, updated with claim_ack_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spur_cnt_o <= '0;
    end else if (claim_req_i && !irq_o && (spur_cnt_o != 16'hFFFF)) begin
      spur_cnt_o <= spur_cnt_o + 16'd1;
    end
  end
`else
  assign spur_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv_plic_scan_arb.sv
// Self-checking bench for rv_plic_scan_arb: steady-state vector table plus
// hand-written claim / commit / reset sequences, claims scored via a queue.
module tb_rv_plic_scan_arb;

  localparam int NS = 55;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NS-1:0]   ip = '0;
  logic [NS-1:0]   ie = '0;
  logic [NS*PW-1:0] prio = '0;
  logic [PW-1:0]   thr = '0;
  logic            claim_req = 1'b0;
  logic            claim_ack;
  logic [5:0]      claim_id;
  logic [NS-1:0]   claim_vec;
  logic            irq;
  logic [5:0]      irq_id;
  logic [15:0]     spur_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]    id;
    logic [NS-1:0] onehot;
    logic [15:0]   spur;
  } claim_exp_t;
  claim_exp_t exp_q[$];
  logic [15:0] exp_spur = '0;

  typedef struct {
    string         name;
    logic [NS-1:0] ip;
    logic [NS-1:0] ie;
    logic [NS*PW-1:0] prio;
    logic [PW-1:0] thr;
    logic          exp_irq;
    logic [5:0]    exp_id;
  } vec_t;
  vec_t vecs[10];

  rv_plic_scan_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ip_i        (ip),
    .ie_i        (ie),
    .prio_i      (prio),
    .threshold_i (thr),
    .claim_req_i (claim_req),
    .claim_ack_o (claim_ack),
    .claim_id_o  (claim_id),
    .claim_o     (claim_vec),
    .irq_o       (irq),
    .irq_id_o    (irq_id),
    .spur_cnt_o  (spur_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] b(int i);
    logic [NS-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NS*PW-1:0] setp(logic [NS*PW-1:0] v, int i, logic [PW-1:0] p);
    v[i*PW +: PW] = p;
    return v;
  endfunction

  // Scoreboard: every claim_ack is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && claim_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(claim_ack), 64'd0);
      end else begin
        claim_exp_t e;
        e = exp_q.pop_front();
        check("claim_id", 64'(claim_id), 64'(e.id));
        check("claim_onehot", 64'(claim_vec), 64'(e.onehot));
        check("spur_cnt", 64'(spur_cnt), 64'(e.spur));
      end
    end
  end

  task automatic expect_claim(logic [5:0] id, logic valid);
    claim_exp_t e;
    e.id     = valid ? id : 6'd0;
    e.onehot = valid ? b(int'(id)) : '0;
`ifdef RV_PLIC_SCAN_ARB_SPURCNT_EN
    if (!valid && exp_spur != 16'hFFFF) exp_spur = exp_spur + 16'd1;
    e.spur = exp_spur;
`else
    e.spur = 16'd0;
`endif
    exp_q.push_back(e);
  endtask

  // Hold claim_req for n consecutive cycles (called at a negedge).
  task automatic pulse_req(int n);
    claim_req = 1'b1;
    repeat (n) @(negedge clk);
    claim_req = 1'b0;
    #1;
    check("ack_drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("irq_after_claim", 64'(irq), 64'd0);
  endtask

  // Negedges until irq_o rises; 0 if it never does within the budget.
  task automatic wait_rise(output int n);
    n = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (irq) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [NS*PW-1:0] p;

    // Vector table: steady-state winner for a set of static inputs.
    p = setp(setp('0, 3, 2'd1), 40, 2'd3);
    vecs[0] = '{"two_src",    b(3) | b(40), '1, p, 2'd0, 1'b1, 6'd40};
    p = setp(setp('0, 10, 2'd2), 50, 2'd2);
    vecs[1] = '{"tie_low_id", b(10) | b(50), '1, p, 2'd0, 1'b1, 6'd10};
    vecs[2] = '{"thr_mask",   b(10) | b(50), '1, p, 2'd2, 1'b0, 6'd0};
    p = setp('0, 54, 2'd1);
    vecs[3] = '{"last_chunk", b(54), '1, p, 2'd0, 1'b1, 6'd54};
    p = setp(setp('0, 3, 2'd1), 40, 2'd3);
    vecs[4] = '{"ie_mask",    b(3) | b(40), ~b(40), p, 2'd0, 1'b1, 6'd3};
    p = setp('0, 40, 2'd3);
    vecs[5] = '{"thr_max",    b(40), '1, p, 2'd3, 1'b0, 6'd0};
    vecs[6] = '{"prio_zero",  b(20), '1, '0, 2'd0, 1'b0, 6'd0};
    p = setp(setp('0, 7, 2'd2), 8, 2'd2);
    vecs[7] = '{"chunk_edge", b(7) | b(8), '1, p, 2'd0, 1'b1, 6'd7};
    p = setp(setp('0, 47, 2'd1), 48, 2'd2);
    vecs[8] = '{"chunk_edge2", b(47) | b(48), '1, p, 2'd0, 1'b1, 6'd48};
    p = '0;
    for (int i = 0; i < NS; i++) p = setp(p, i, 2'd1);
    p = setp(setp(p, 33, 2'd3), 7, 2'd3);
    vecs[9] = '{"all_pend",   '1, '1, p, 2'd0, 1'b1, 6'd7};

    // Reset with nothing pending.
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_irq_id", 64'(irq_id), 64'd0);
    check("rst_ack", 64'(claim_ack), 64'd0);
    check("rst_claim_id", 64'(claim_id), 64'd0);
    check("rst_claim_o", 64'(claim_vec), 64'd0);
    check("rst_spur", 64'(spur_cnt), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_irq", 64'({irq, irq_id}), 64'd0);
    end

    // Claim with nothing pending: ID 0, no one-hot, spurious count.
    expect_claim(6'd0, 1'b0);
    pulse_req(1);

    // Steady-state table.
    foreach (vecs[v]) begin
      ip = vecs[v].ip; ie = vecs[v].ie; prio = vecs[v].prio; thr = vecs[v].thr;
      repeat (16) @(negedge clk);
      check({vecs[v].name, "_irq"}, 64'(irq), 64'(vecs[v].exp_irq));
      check({vecs[v].name, "_id"}, 64'(irq_id), 64'(vecs[v].exp_id));
      check({vecs[v].name, "_no_x"},
            64'($isunknown({irq, irq_id, claim_ack, claim_id, claim_vec, spur_cnt})), 64'd0);
    end

    // Claim ID 40, gateway clears ip[40], ID 3 follows one sweep later.
    ip = vecs[0].ip; ie = '1; prio = vecs[0].prio; thr = '0;
    repeat (16) @(negedge clk);
    check("pre_claim_id", 64'(irq_id), 64'd40);
    expect_claim(6'd40, 1'b1);
    pulse_req(1);
    ip[40] = 1'b0;
    wait_rise(n);
    check("restart_latency", 64'(n), 64'd8);
    check("next_winner", 64'(irq_id), 64'd3);

    // We are just after a commit edge. Raise a better source so the next
    // commit would pick 20, then claim exactly in that COMMIT cycle and
    // again in the following cycle.
    prio = setp(prio, 20, 2'd3);
    ip[20] = 1'b1;
    repeat (7) @(negedge clk);
    expect_claim(6'd3, 1'b1);
    expect_claim(6'd0, 1'b0);
    pulse_req(2);
    ip[3] = 1'b0;
    wait_rise(n);
    check("b2b_restart_latency", 64'(n), 64'd8);
    check("b2b_next_winner", 64'(irq_id), 64'd20);

    // Asynchronous reset mid-sweep, then the first full sweep commits.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_irq", 64'({irq, irq_id}), 64'd0);
    check("async_rst_spur", 64'(spur_cnt), 64'd0);
    exp_spur = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise(n);
    check("post_rst_latency", 64'(n), 64'd8);
    check("post_rst_id", 64'(irq_id), 64'd20);

    // Spurious count restarts from zero after reset.
    repeat (2) @(negedge clk);
    expect_claim(6'd20, 1'b1);
    pulse_req(1);
    expect_claim(6'd0, 1'b0);
    pulse_req(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
